uart_tx_fifo: RTL

Parametrised UART transmitter; next generation of the team's single-byte 8N1 transmitter.
- Word width, parity mode, stop-bit count and baud divisor are parameters.
- A FIFO_DEPTH-entry FIFO with a valid/ready write port lets software or the CPU bus queue bytes.
- Frames go out back-to-back with no idle gap.
- Sits between the Y86 memory-mapped I/O path and the board's serial TX pin.

---
 rtl/uart_tx_fifo.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: parametrised UART transmitter fed by a small valid/ready write FIFO.
// Frames are start bit, DATA_BITS data bits LSB first, optional parity bit and
// STOP_BITS stop bits. Queued words go out back-to-back with no idle gap.
module uart_tx_fifo #(
  parameter int CLK_DIV    = 2604,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [DATA_BITS-1:0]        tx_data,
  input  logic                        tx_valid,
  output logic                        tx_ready,
  output logic                        txd,
  output logic                        busy,
  output logic                        tx_done,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = $clog2(CLK_DIV);
  localparam int BIT_W  = $clog2(DATA_BITS + 1);

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 push;
  logic                 pop;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] head;

  state_t               state;
  state_t               state_next;
  logic [BAUD_W-1:0]    baud_cnt;
  logic [BAUD_W-1:0]    baud_next;
  logic [BIT_W-1:0]     bit_cnt;
  logic [BIT_W-1:0]     bit_next;
  logic [DATA_BITS-1:0] shift_reg;
  logic [DATA_BITS-1:0] shift_next;
  logic                 parity_reg;
  logic                 parity_next;
  logic                 txd_next;
  logic                 done_next;
  logic                 bit_tick;

  // Parity bit for a whole word: even mode makes the total ones count even, odd mode odd.
  function automatic logic parity_of(input logic [DATA_BITS-1:0] w);
    return (PARITY == 1) ? ~(^w) : (^w);
  endfunction

  assign tx_ready   = (fifo_count != CNT_FULL);
  assign push       = tx_valid & tx_ready;
  assign fifo_empty = (fifo_count == '0);
  assign head       = mem[rd_ptr];
  assign busy       = (state != IDLE);
  assign bit_tick   = (baud_cnt == BAUD_LAST);

  // FIFO storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= tx_data;
    end
  end

  // Wrapping pointers and occupancy count; a push and pop together leave the count alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CNT_W'(1);
        2'b01:   fifo_count <= fifo_count - CNT_W'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Sequencer registers, including the registered serial output and done pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_reg <= 1'b0;
      txd        <= 1'b1;
      tx_done    <= 1'b0;
    end else begin
      state      <= state_next;
      baud_cnt   <= baud_next;
      bit_cnt    <= bit_next;
      shift_reg  <= shift_next;
      parity_reg <= parity_next;
      txd        <= txd_next;
      tx_done    <= done_next;
    end
  end

  // Next-state logic: each bit lasts CLK_DIV cycles, and the end of the last stop bit
  // pops the next word straight into a new start bit when one is waiting.
  always_comb begin
    state_next  = state;
    baud_next   = baud_cnt + BAUD_W'(1);
    bit_next    = bit_cnt;
    shift_next  = shift_reg;
    parity_next = parity_reg;
    done_next   = 1'b0;
    pop         = 1'b0;
    case (state)
      IDLE: begin
        baud_next = '0;
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_next  = head;
          parity_next = parity_of(head);
          bit_next    = '0;
          state_next  = START;
        end
      end
      START: begin
        if (bit_tick) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = DATA;
        end
      end
      DATA: begin
        if (bit_tick) begin
          baud_next = '0;
          if (bit_cnt == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY != 0) ? PAR : STOP;
          end else begin
            bit_next   = bit_cnt + BIT_W'(1);
            shift_next = shift_reg >> 1;
          end
        end
      end
      PAR: begin
        if (bit_tick) begin
          baud_next  = '0;
          bit_next   = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_tick) begin
          baud_next = '0;
          if (bit_cnt == STOP_LAST) begin
            done_next = 1'b1;
            bit_next  = '0;
            if (!fifo_empty) begin
              pop         = 1'b1;
              shift_next  = head;
              parity_next = parity_of(head);
              state_next  = START;
            end else begin
              state_next = IDLE;
            end
          end else begin
            bit_next = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        state_next = IDLE;
        baud_next  = '0;
        bit_next   = '0;
      end
    endcase
  end

  // Line level for the state being entered, so txd changes on the same edge as the state.
  always_comb begin
    txd_next = 1'b1;
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_next[0];
      PAR:     txd_next = parity_next;
      default: txd_next = 1'b1;
    endcase
  end

endmodule
